pipelined_addsub: RTL

Parametrised, pipelined two's-complement adder/subtractor for the wide datapath of the matrix-multiply engine. It replaces the fixed-width combinational add/sub core. The carry chain is split into CHUNK-bit slices, one slice per pipeline stage, so WIDTH can exceed what closes timing in one cycle. A per-operation add/sub select, a sideband tag, and valid/ready backpressure let it sit directly between the MAC array and the accumulation buffer.

---
 rtl/pipelined_addsub_pkg.sv | 18 +
 rtl/pipelined_addsub_slice.sv | 16 +
 rtl/pipelined_addsub.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipelined_addsub_pkg.sv
// Helpers for sizing the carry-chain slices of pipelined_addsub.
package addsub_pkg;

    // Number of pipeline stages: ceil((width+1)/chunk).
    function automatic int num_stages(input int width, input int chunk);
        return (width + chunk) / chunk;
    endfunction

    function automatic int slice_w(input int width, input int chunk, input int k);
        int lo;
        int hi;
        lo = k * chunk;
        hi = (k + 1) * chunk;
        if (hi > width + 1) hi = width + 1;
        return hi - lo;
    endfunction

endpackage

// File: rtl/pipelined_addsub_slice.sv
// One carry-chain slice: W-bit add with carry-in and carry-out.
module addsub_slice #(
    parameter int W = 30
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    logic [W:0] sum_full;

    assign sum_full = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};
    assign s_o      = sum_full[W-1:0];
    assign c_o      = sum_full[W];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined signed add/sub: one CHUNK-bit carry slice per stage, global stall.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 89,
    parameter int CHUNK = 30,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s,
    output logic [TAG_W-1:0] out_tag
);
    localparam int W1     = WIDTH + 1;
    localparam int STAGES = num_stages(WIDTH, CHUNK);

    logic          advance;
    logic [W1-1:0] a_ext;
    logic [W1-1:0] b_ext;

    // Subtract is a + ~b + 1; the +1 enters as carry-in of slice 0.
    assign a_ext = {a[WIDTH-1], a};
    assign b_ext = sub ? ~{b[WIDTH-1], b} : {b[WIDTH-1], b};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * CHUNK;
        localparam int SW   = slice_w(WIDTH, CHUNK, k);
        localparam int IW   = W1 - LO;
        localparam int PEND = IW - SW;

        logic             prv_valid;
        logic             prv_carry;
        logic [TAG_W-1:0] prv_tag;
        logic [IW-1:0]    prv_a;
        logic [IW-1:0]    prv_b;
        logic [SW-1:0]    slice_sum;
        logic             slice_co;
        logic [LO+SW-1:0] sum_d;
        logic [LO+SW-1:0] sum_q;
        logic             valid_q;
        logic [TAG_W-1:0] tag_q;

        if (k == 0) begin : g_head
            assign prv_valid = in_valid;
            assign prv_carry = sub;
            assign prv_tag   = in_tag;
            assign prv_a     = a_ext;
            assign prv_b     = b_ext;
            assign sum_d     = slice_sum;
        end else begin : g_body
            assign prv_valid = g_stage[k-1].valid_q;
            assign prv_carry = g_stage[k-1].g_fwd.carry_q;
            assign prv_tag   = g_stage[k-1].tag_q;
            assign prv_a     = g_stage[k-1].g_fwd.a_q;
            assign prv_b     = g_stage[k-1].g_fwd.b_q;
            assign sum_d     = {slice_sum, g_stage[k-1].sum_q};
        end

        addsub_slice #(.W(SW)) u_slice (
            .a_i (prv_a[SW-1:0]),
            .b_i (prv_b[SW-1:0]),
            .c_i (prv_carry),
            .s_o (slice_sum),
            .c_o (slice_co)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                tag_q   <= '0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= prv_valid;
                tag_q   <= prv_tag;
                sum_q   <= sum_d;
            end
        end

        // Non-final stages carry their carry-out and the not-yet-added operand bits.
        if (k < STAGES - 1) begin : g_fwd
            logic            carry_q;
            logic [PEND-1:0] a_q;
            logic [PEND-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    carry_q <= 1'b0;
                end else if (advance) begin
                    carry_q <= slice_co;
                end
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= prv_a[IW-1:SW];
                    b_q <= prv_b[IW-1:SW];
                end
            end
        end else begin : g_tail
            logic unused_carry;
            assign unused_carry = slice_co;
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign s         = g_stage[STAGES-1].sum_q;
    assign out_tag   = g_stage[STAGES-1].tag_q;

    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;
endmodule
